// File: rtl/apu_pkg.sv
// Shared constants, state type and address helpers for the APU ARAM access controller.
package apu_pkg;

  localparam logic [15:0] SMP_DSPADDR = 16'h00F2;
  localparam logic [15:0] SMP_DSPDATA = 16'h00F3;
  localparam logic [11:0] IO_PAGE     = 12'h00F;

  typedef enum logic [1:0] {
    IDLE,
    SMP_ACC,
    DSP_ACC
  } mem_state_t;

  function automatic logic is_io_page(input logic [15:0] a);
    return a[15:4] == IO_PAGE;
  endfunction

  function automatic logic is_reg_port(input logic [15:0] a);
    return (a == SMP_DSPADDR) || (a == SMP_DSPDATA);
  endfunction

endpackage

// File: rtl/apu_dsp_regport.sv
// DSPADDR latch and $00F2/$00F3 decode: drives the DSP register port and selects the
// read data returned to the SMP.
module apu_dsp_regport
  import apu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cap_i,
  input  logic        dec_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  wdata_i,
  input  logic        we_n_i,
  input  logic        aram_rvalid_i,
  input  logic [7:0]  aram_rdata_i,
  input  logic [7:0]  dsp_reg_di_i,
  output logic [7:0]  smp_di_o,
  output logic [6:0]  dsp_reg_a_o,
  output logic [7:0]  dsp_reg_do_o,
  output logic        dsp_reg_we_o
);

  logic [7:0] dspaddr_q;
  logic [7:0] smp_di_q;
  logic [7:0] reg_do_q;
  logic       reg_we_q;
  logic       f3_rd_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dspaddr_q <= 8'h00;
      smp_di_q  <= 8'h00;
      reg_do_q  <= 8'h00;
      reg_we_q  <= 1'b0;
      f3_rd_q   <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      if (cap_i) begin
        f3_rd_q <= 1'b0;
      end
      if (aram_rvalid_i) begin
        smp_di_q <= aram_rdata_i;
      end
      if (dec_i) begin
        if (!we_n_i) begin
          if (a_i == SMP_DSPADDR) begin
            dspaddr_q <= wdata_i;
          end else if ((a_i == SMP_DSPDATA) && !dspaddr_q[7]) begin
            // Bit 7 set makes the DSP register file read-only from the SMP.
            reg_we_q <= 1'b1;
            reg_do_q <= wdata_i;
          end
        end else begin
          if (a_i == SMP_DSPADDR) begin
            smp_di_q <= dspaddr_q;
          end else if (a_i == SMP_DSPDATA) begin
            f3_rd_q <= 1'b1;
          end
        end
      end
    end
  end

  // $00F3 reads track the DSP register file live until the next SMP capture.
  assign smp_di_o     = f3_rd_q ? dsp_reg_di_i : smp_di_q;
  assign dsp_reg_a_o  = dspaddr_q[6:0];
  assign dsp_reg_do_o = reg_do_q;
  assign dsp_reg_we_o = reg_we_q;

endmodule

// File: rtl/apu_mem_ctrl.sv
// ARAM access controller: captures SMP steps, arbitrates SMP and DSP onto the single
// audio-RAM req/ack port and flags SMP accesses that miss their step deadline.
module apu_mem_ctrl
  import apu_pkg::*;
#(
  parameter bit IO_WRITE_THROUGH = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SMP_CE,
  input  logic [15:0] SMP_A,
  input  logic [7:0]  SMP_DO,
  input  logic        SMP_WE_N,
  output logic [7:0]  SMP_DI,
  input  logic        DSP_REQ,
  input  logic [15:0] DSP_A,
  input  logic [7:0]  DSP_DO,
  input  logic        DSP_WE_N,
  output logic        DSP_ACK,
  output logic [7:0]  DSP_DI,
  output logic [6:0]  DSP_REG_A,
  output logic [7:0]  DSP_REG_DO,
  output logic        DSP_REG_WE,
  input  logic [7:0]  DSP_REG_DI,
  output logic        MEM_REQ,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_WE,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DI,
  output logic        LATE
);

  mem_state_t  state_q;
  logic        ce_d1_q;
  logic        dec_q;
  logic        smp_pend_q;
  logic        late_q;
  logic [15:0] lat_a_q;
  logic [7:0]  lat_do_q;
  logic        lat_we_n_q;
  logic        mem_req_q;
  logic [15:0] mem_a_q;
  logic [7:0]  mem_do_q;
  logic        mem_we_q;
  logic        dsp_ack_q;
  logic [7:0]  dsp_di_q;

  logic smp_cap;
  logic smp_aram;
  logic dsp_grant;
  logic aram_rvalid;

  assign smp_cap  = ce_d1_q && !smp_pend_q;
  assign smp_aram = lat_we_n_q ? !is_reg_port(lat_a_q)
                               : (!is_io_page(lat_a_q) || IO_WRITE_THROUGH);
  // Hold the DSP off while an SMP capture is imminent or outstanding, and during the
  // DSP_ACK cycle so a level request that has not yet dropped is not serviced twice.
  assign dsp_grant   = DSP_REQ && !ce_d1_q && !smp_pend_q && !dsp_ack_q;
  assign aram_rvalid = (state_q == SMP_ACC) && MEM_ACK && lat_we_n_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ce_d1_q    <= 1'b0;
      dec_q      <= 1'b0;
      smp_pend_q <= 1'b0;
      late_q     <= 1'b0;
      lat_a_q    <= 16'h0000;
      lat_do_q   <= 8'h00;
      lat_we_n_q <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_a_q    <= 16'h0000;
      mem_do_q   <= 8'h00;
      mem_we_q   <= 1'b0;
      dsp_ack_q  <= 1'b0;
      dsp_di_q   <= 8'h00;
    end else begin
      ce_d1_q   <= SMP_CE;
      dec_q     <= 1'b0;
      dsp_ack_q <= 1'b0;

      if (ce_d1_q) begin
        if (smp_pend_q) begin
          late_q <= 1'b1;
        end else begin
          lat_a_q    <= SMP_A;
          lat_do_q   <= SMP_DO;
          lat_we_n_q <= SMP_WE_N;
          smp_pend_q <= 1'b1;
          dec_q      <= 1'b1;
        end
      end

      if (dec_q && !smp_aram) begin
        smp_pend_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (smp_pend_q && smp_aram) begin
            state_q   <= SMP_ACC;
            mem_req_q <= 1'b1;
            mem_a_q   <= lat_a_q;
            mem_do_q  <= lat_do_q;
            mem_we_q  <= !lat_we_n_q;
          end else if (dsp_grant) begin
            state_q   <= DSP_ACC;
            mem_req_q <= 1'b1;
            mem_a_q   <= DSP_A;
            mem_do_q  <= DSP_DO;
            mem_we_q  <= !DSP_WE_N;
          end
        end
        SMP_ACC: begin
          if (MEM_ACK) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            smp_pend_q <= 1'b0;
          end
        end
        DSP_ACC: begin
          if (MEM_ACK) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            dsp_di_q  <= MEM_DI;
            dsp_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  apu_dsp_regport u_regport (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .cap_i         (smp_cap),
    .dec_i         (dec_q),
    .a_i           (lat_a_q),
    .wdata_i       (lat_do_q),
    .we_n_i        (lat_we_n_q),
    .aram_rvalid_i (aram_rvalid),
    .aram_rdata_i  (MEM_DI),
    .dsp_reg_di_i  (DSP_REG_DI),
    .smp_di_o      (SMP_DI),
    .dsp_reg_a_o   (DSP_REG_A),
    .dsp_reg_do_o  (DSP_REG_DO),
    .dsp_reg_we_o  (DSP_REG_WE)
  );

  assign MEM_REQ = mem_req_q;
  assign MEM_A   = mem_a_q;
  assign MEM_DO  = mem_do_q;
  assign MEM_WE  = mem_we_q;
  assign DSP_ACK = dsp_ack_q;
  assign DSP_DI  = dsp_di_q;
  assign LATE    = late_q;

endmodule

// File: tb/tb_apu_mem_ctrl.sv
// Directed bench for apu_mem_ctrl: an ARAM responder model plus a queue of expected
// ARAM transactions checked as each MEM_REQ is raised.
module tb_apu_mem_ctrl;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
  } txn_t;

  logic        CLK;
  logic        RST_N;
  logic        SMP_CE;
  logic [15:0] SMP_A;
  logic [7:0]  SMP_DO;
  logic        SMP_WE_N;
  logic [7:0]  SMP_DI;
  logic        DSP_REQ;
  logic [15:0] DSP_A;
  logic [7:0]  DSP_DO;
  logic        DSP_WE_N;
  logic        DSP_ACK;
  logic [7:0]  DSP_DI;
  logic [6:0]  DSP_REG_A;
  logic [7:0]  DSP_REG_DO;
  logic        DSP_REG_WE;
  logic [7:0]  DSP_REG_DI;
  logic        MEM_REQ;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_DO;
  logic        MEM_WE;
  logic        MEM_ACK;
  logic [7:0]  MEM_DI;
  logic        LATE;

  apu_mem_ctrl #(
    .IO_WRITE_THROUGH (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SMP_CE     (SMP_CE),
    .SMP_A      (SMP_A),
    .SMP_DO     (SMP_DO),
    .SMP_WE_N   (SMP_WE_N),
    .SMP_DI     (SMP_DI),
    .DSP_REQ    (DSP_REQ),
    .DSP_A      (DSP_A),
    .DSP_DO     (DSP_DO),
    .DSP_WE_N   (DSP_WE_N),
    .DSP_ACK    (DSP_ACK),
    .DSP_DI     (DSP_DI),
    .DSP_REG_A  (DSP_REG_A),
    .DSP_REG_DO (DSP_REG_DO),
    .DSP_REG_WE (DSP_REG_WE),
    .DSP_REG_DI (DSP_REG_DI),
    .MEM_REQ    (MEM_REQ),
    .MEM_A      (MEM_A),
    .MEM_DO     (MEM_DO),
    .MEM_WE     (MEM_WE),
    .MEM_ACK    (MEM_ACK),
    .MEM_DI     (MEM_DI),
    .LATE       (LATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   vectors;
  int   miscompares;
  txn_t exp_q[$];
  txn_t e;
  int   num_req;
  int   reg_we_cnt;
  int   dsp_ack_cnt;
  int   wait_cnt;
  int   ack_delay;
  logic ack_en;
  logic acked;
  logic req_seen;
  logic [7:0] mem_rdata;
  int   req_base;
  int   we_base;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: sample just after the edge, then act as the ARAM and the DSP.
  task automatic tick();
    @(posedge CLK);
    #1;
    MEM_ACK = 1'b0;
    if (MEM_REQ && !req_seen) begin
      req_seen = 1'b1;
      acked    = 1'b0;
      wait_cnt = 0;
      num_req++;
      if (exp_q.size() == 0) begin
        chk("unexpected_mem_req", 16'(MEM_REQ), 16'h0000);
      end else begin
        e = exp_q.pop_front();
        chk("mem_a", MEM_A, e.a);
        chk("mem_we", 16'(MEM_WE), 16'(e.we));
        if (e.we) chk("mem_do", 16'(MEM_DO), 16'(e.d));
      end
    end
    if (MEM_REQ && req_seen && !acked) begin
      wait_cnt++;
      if (ack_en && (wait_cnt >= ack_delay)) begin
        MEM_ACK = 1'b1;
        MEM_DI  = mem_rdata;
        acked   = 1'b1;
      end
    end
    if (!MEM_REQ) req_seen = 1'b0;
    if (DSP_REG_WE) reg_we_cnt++;
    if (DSP_ACK) begin
      dsp_ack_cnt++;
      DSP_REQ = 1'b0;
    end
  endtask

  // One SMP step of 8 clocks; optionally raises DSP_REQ in the ce_d1 cycle.
  task automatic smp_step(input logic [15:0] a, input logic [7:0] d, input logic we_n,
                          input logic dsp_go);
    SMP_A    = a;
    SMP_DO   = d;
    SMP_WE_N = we_n;
    SMP_CE   = 1'b1;
    tick();
    SMP_CE = 1'b0;
    if (dsp_go) DSP_REQ = 1'b1;
    for (int i = 1; i < 8; i++) tick();
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d, input logic we);
    txn_t t;
    t.a  = a;
    t.d  = d;
    t.we = we;
    exp_q.push_back(t);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    num_req     = 0;
    reg_we_cnt  = 0;
    dsp_ack_cnt = 0;
    wait_cnt    = 0;
    ack_delay   = 3;
    ack_en      = 1'b1;
    acked       = 1'b0;
    req_seen    = 1'b0;
    mem_rdata   = 8'h00;
    RST_N       = 1'b0;
    SMP_CE      = 1'b0;
    SMP_A       = 16'h0000;
    SMP_DO      = 8'h00;
    SMP_WE_N    = 1'b1;
    DSP_REQ     = 1'b0;
    DSP_A       = 16'h0000;
    DSP_DO      = 8'h00;
    DSP_WE_N    = 1'b1;
    DSP_REG_DI  = 8'h00;
    MEM_ACK     = 1'b0;
    MEM_DI      = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_smp_di", 16'(SMP_DI), 16'h0000);
    chk("rst_dsp_ack", 16'(DSP_ACK), 16'h0000);
    chk("rst_dsp_di", 16'(DSP_DI), 16'h0000);
    chk("rst_reg_a", 16'(DSP_REG_A), 16'h0000);
    chk("rst_reg_do", 16'(DSP_REG_DO), 16'h0000);
    chk("rst_reg_we", 16'(DSP_REG_WE), 16'h0000);
    chk("rst_mem_req", 16'(MEM_REQ), 16'h0000);
    chk("rst_mem_a", MEM_A, 16'h0000);
    chk("rst_mem_do", 16'(MEM_DO), 16'h0000);
    chk("rst_mem_we", 16'(MEM_WE), 16'h0000);
    chk("rst_late", 16'(LATE), 16'h0000);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("idle_no_req", 16'(num_req), 16'h0000);

    // Plain ARAM read
    mem_rdata = 8'hA5;
    req_base  = num_req;
    push(16'h1234, 8'h00, 1'b0);
    smp_step(16'h1234, 8'h00, 1'b1, 1'b0);
    chk("read_1234_di", 16'(SMP_DI), 16'h00A5);
    chk("read_1234_nreq", 16'(num_req - req_base), 16'h0001);

    // DSP register path, DSPADDR = $0C (the $00F2 write also goes through to ARAM)
    push(16'h00F2, 8'h0C, 1'b1);
    smp_step(16'h00F2, 8'h0C, 1'b0, 1'b0);
    chk("reg_a_0c", 16'(DSP_REG_A), 16'h000C);
    DSP_REG_DI = 8'h55;
    req_base   = num_req;
    smp_step(16'h00F3, 8'h00, 1'b1, 1'b0);
    chk("f3_read_di", 16'(SMP_DI), 16'h0055);
    chk("f3_read_nreq", 16'(num_req - req_base), 16'h0000);
    DSP_REG_DI = 8'h5A;
    #1;
    chk("f3_read_follow", 16'(SMP_DI), 16'h005A);

    we_base = reg_we_cnt;
    push(16'h00F3, 8'h22, 1'b1);
    smp_step(16'h00F3, 8'h22, 1'b0, 1'b0);
    chk("f3_write_we", 16'(reg_we_cnt - we_base), 16'h0001);
    chk("f3_write_do", 16'(DSP_REG_DO), 16'h0022);

    req_base = num_req;
    smp_step(16'h00F2, 8'h00, 1'b1, 1'b0);
    chk("f2_read_di", 16'(SMP_DI), 16'h000C);
    chk("f2_read_nreq", 16'(num_req - req_base), 16'h0000);

    // DSPADDR bit 7 set: $00F3 write must not reach the DSP, only ARAM
    push(16'h00F2, 8'h8C, 1'b1);
    smp_step(16'h00F2, 8'h8C, 1'b0, 1'b0);
    we_base = reg_we_cnt;
    push(16'h00F3, 8'h11, 1'b1);
    smp_step(16'h00F3, 8'h11, 1'b0, 1'b0);
    chk("f3_ro_we", 16'(reg_we_cnt - we_base), 16'h0000);
    chk("f3_ro_reg_a", 16'(DSP_REG_A), 16'h000C);
    DSP_REG_DI = 8'h3E;
    smp_step(16'h00F3, 8'h00, 1'b1, 1'b0);
    chk("f3_ro_read_di", 16'(SMP_DI), 16'h003E);

    // Arbitration: SMP write wins over a DSP read raised in the ce_d1 cycle
    DSP_A     = 16'h2000;
    DSP_WE_N  = 1'b1;
    mem_rdata = 8'hC3;
    req_base  = num_req;
    push(16'h3000, 8'h77, 1'b1);
    push(16'h2000, 8'h00, 1'b0);
    smp_step(16'h3000, 8'h77, 1'b0, 1'b1);
    for (int i = 0; (i < 30) && (dsp_ack_cnt == 0); i++) tick();
    for (int i = 0; i < 4; i++) tick();
    chk("arb_dsp_ack_cnt", 16'(dsp_ack_cnt), 16'h0001);
    chk("arb_dsp_di", 16'(DSP_DI), 16'h00C3);
    chk("arb_nreq", 16'(num_req - req_base), 16'h0002);

    // Deadline: ACK withheld across the next SMP step
    ack_en    = 1'b0;
    mem_rdata = 8'h3C;
    req_base  = num_req;
    push(16'h4000, 8'h00, 1'b0);
    smp_step(16'h4000, 8'h00, 1'b1, 1'b0);
    chk("late_before", 16'(LATE), 16'h0000);
    smp_step(16'h5000, 8'h00, 1'b1, 1'b0);
    chk("late_set", 16'(LATE), 16'h0001);
    ack_en = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("late_read_di", 16'(SMP_DI), 16'h003C);
    chk("late_nreq", 16'(num_req - req_base), 16'h0001);
    chk("late_sticky", 16'(LATE), 16'h0001);
    mem_rdata = 8'h96;
    push(16'h6000, 8'h00, 1'b0);
    smp_step(16'h6000, 8'h00, 1'b1, 1'b0);
    chk("after_late_di", 16'(SMP_DI), 16'h0096);
    chk("after_late_sticky", 16'(LATE), 16'h0001);

    // Reset while in SMP_ACC, then a stray ACK
    ack_en = 1'b0;
    push(16'h7000, 8'h00, 1'b0);
    SMP_A    = 16'h7000;
    SMP_WE_N = 1'b1;
    SMP_CE   = 1'b1;
    tick();
    SMP_CE = 1'b0;
    for (int i = 0; (i < 10) && !MEM_REQ; i++) tick();
    chk("mid_req_up", 16'(MEM_REQ), 16'h0001);
    req_base = num_req;
    we_base  = dsp_ack_cnt;
    RST_N    = 1'b0;
    tick();
    chk("mid_req_drop", 16'(MEM_REQ), 16'h0000);
    RST_N = 1'b1;
    tick();
    MEM_ACK = 1'b1;
    MEM_DI  = 8'hEE;
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("mid_smp_di", 16'(SMP_DI), 16'h0000);
    chk("mid_no_req", 16'(num_req - req_base), 16'h0000);
    chk("mid_req_low", 16'(MEM_REQ), 16'h0000);
    chk("mid_late_clr", 16'(LATE), 16'h0000);
    chk("mid_no_dsp_ack", 16'(dsp_ack_cnt - we_base), 16'h0000);
    chk("exp_q_empty", 16'(exp_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
